// File: rtl/branch_predict_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_bht
// Brief    : PC-indexed table of saturating counters, bimodal or gshare, with
//            ID-stage mispredict flag and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_bht #(
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 0,
    parameter int PERF_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  if_valid,
    input  logic [31:0]           if_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_idx,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_pred,
    input  logic                  upd_taken,
    output logic                  mispredict,
    output logic [PERF_BITS-1:0]  perf_branches,
    output logic [PERF_BITS-1:0]  perf_mispred
);

    localparam int                   C_ENTRIES   = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]  C_CTR_INIT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0]  C_CTR_MAX   = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]  C_CTR_ONE   = CTR_BITS'(1);
    localparam logic [PERF_BITS-1:0] C_PERF_MAX  = {PERF_BITS{1'b1}};
    localparam logic [PERF_BITS-1:0] C_PERF_ONE  = PERF_BITS'(1);

    logic [CTR_BITS-1:0]   r_ctr_q [C_ENTRIES];
    logic [CTR_BITS-1:0]   w_ctr_d [C_ENTRIES];
    logic [PERF_BITS-1:0]  r_perf_br_q;
    logic [PERF_BITS-1:0]  w_perf_br_d;
    logic [PERF_BITS-1:0]  r_perf_mis_q;
    logic [PERF_BITS-1:0]  w_perf_mis_d;
    logic [INDEX_BITS-1:0] w_hist_idx;
    logic                  w_commit;
    logic                  w_unused_pc;

    assign w_commit    = upd_valid & ~stall;
    assign mispredict  = upd_valid & (upd_pred ^ upd_taken);
    assign w_unused_pc = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0]};

    // History is built from resolved outcomes only, so it never needs repair.
    generate
        if (GHR_BITS > 0) begin : g_gshare
            logic [GHR_BITS-1:0] r_ghr_q;
            logic [GHR_BITS-1:0] w_ghr_d;

            always_comb begin
                w_ghr_d = r_ghr_q;
                if (w_commit) begin
                    w_ghr_d = GHR_BITS'({r_ghr_q, upd_taken});
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ghr_q <= '0;
                end else begin
                    r_ghr_q <= w_ghr_d;
                end
            end

            assign w_hist_idx = INDEX_BITS'(r_ghr_q);
        end else begin : g_bimodal
            assign w_hist_idx = '0;
        end
    endgenerate

    assign pred_idx   = if_pc[INDEX_BITS+1:2] ^ w_hist_idx;
    assign pred_taken = if_valid & r_ctr_q[pred_idx][CTR_BITS-1];

    always_comb begin
        w_ctr_d = r_ctr_q;
        if (w_commit) begin
            if (upd_taken) begin
                if (r_ctr_q[upd_idx] != C_CTR_MAX) begin
                    w_ctr_d[upd_idx] = r_ctr_q[upd_idx] + C_CTR_ONE;
                end
            end else if (r_ctr_q[upd_idx] != '0) begin
                w_ctr_d[upd_idx] = r_ctr_q[upd_idx] - C_CTR_ONE;
            end
        end
    end

    always_comb begin
        w_perf_br_d  = r_perf_br_q;
        w_perf_mis_d = r_perf_mis_q;
        if (w_commit) begin
            if (r_perf_br_q != C_PERF_MAX) begin
                w_perf_br_d = r_perf_br_q + C_PERF_ONE;
            end
            if (mispredict && (r_perf_mis_q != C_PERF_MAX)) begin
                w_perf_mis_d = r_perf_mis_q + C_PERF_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_ENTRIES; i++) begin
                r_ctr_q[i] <= C_CTR_INIT;
            end
            r_perf_br_q  <= '0;
            r_perf_mis_q <= '0;
        end else begin
            r_ctr_q      <= w_ctr_d;
            r_perf_br_q  <= w_perf_br_d;
            r_perf_mis_q <= w_perf_mis_d;
        end
    end

    assign perf_branches = r_perf_br_q;
    assign perf_mispred  = r_perf_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_bht
// Brief    : Bimodal and gshare instances on shared stimulus, each checked
//            every cycle against a table-of-integers reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_bht;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic        upd_pred;
    logic        upd_taken;

    logic        bi_pred_taken;
    logic [3:0]  bi_pred_idx;
    logic        bi_mis;
    logic [15:0] bi_pb;
    logic [15:0] bi_pm;

    logic        gs_pred_taken;
    logic [3:0]  gs_pred_idx;
    logic        gs_mis;
    logic [3:0]  gs_pb;
    logic [3:0]  gs_pm;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: index 0 = bimodal instance, 1 = gshare (2-bit history, 4-bit perf)
    int m_ctr [2][16];
    int m_ghr [2];
    int m_pb  [2];
    int m_pm  [2];
    int c_gbits [2] = '{0, 2};
    int c_pmax  [2] = '{65535, 15};

    branch_predict_bht #(
        .INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(0), .PERF_BITS(16)
    ) u_bi (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(bi_pred_taken), .pred_idx(bi_pred_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_pred(upd_pred),
        .upd_taken(upd_taken), .mispredict(bi_mis),
        .perf_branches(bi_pb), .perf_mispred(bi_pm)
    );

    branch_predict_bht #(
        .INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(2), .PERF_BITS(4)
    ) u_gs (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(gs_pred_taken), .pred_idx(gs_pred_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_pred(upd_pred),
        .upd_taken(upd_taken), .mispredict(gs_mis),
        .perf_branches(gs_pb), .perf_mispred(gs_pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m_ctr[k][i] = 1;
            m_ghr[k] = 0;
            m_pb[k]  = 0;
            m_pm[k]  = 0;
        end
    endtask

    function automatic int exp_idx(input int k);
        return int'(if_pc[5:2]) ^ m_ghr[k];
    endfunction

    function automatic int exp_pred(input int k);
        return (if_valid && (m_ctr[k][exp_idx(k)] >= 2)) ? 1 : 0;
    endfunction

    task automatic model_update();
        int  i;
        bit  mis;
        if (upd_valid && !stall) begin
            i   = int'(upd_idx);
            mis = (upd_pred != upd_taken);
            for (int k = 0; k < 2; k++) begin
                if (upd_taken) m_ctr[k][i] = (m_ctr[k][i] < 3) ? m_ctr[k][i] + 1 : 3;
                else           m_ctr[k][i] = (m_ctr[k][i] > 0) ? m_ctr[k][i] - 1 : 0;
                if (c_gbits[k] > 0)
                    m_ghr[k] = ((m_ghr[k] << 1) | int'(upd_taken)) & ((1 << c_gbits[k]) - 1);
                if (m_pb[k] < c_pmax[k]) m_pb[k]++;
                if (mis && (m_pm[k] < c_pmax[k])) m_pm[k]++;
            end
        end
    endtask

    task automatic compare_all();
        int em;
        em = (upd_valid && (upd_pred != upd_taken)) ? 1 : 0;
        chk("bi_pred_idx",   bi_pred_idx,   exp_idx(0));
        chk("bi_pred_taken", bi_pred_taken, exp_pred(0));
        chk("bi_mispredict", bi_mis,        em);
        chk("bi_perf_br",    bi_pb,         m_pb[0]);
        chk("bi_perf_mis",   bi_pm,         m_pm[0]);
        chk("gs_pred_idx",   gs_pred_idx,   exp_idx(1));
        chk("gs_pred_taken", gs_pred_taken, exp_pred(1));
        chk("gs_mispredict", gs_mis,        em);
        chk("gs_perf_br",    gs_pb,         m_pb[1]);
        chk("gs_perf_mis",   gs_pm,         m_pm[1]);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("bi_ctr[%0d]", i), u_bi.r_ctr_q[i], m_ctr[0][i]);
            chk($sformatf("gs_ctr[%0d]", i), u_gs.r_ctr_q[i], m_ctr[1][i]);
        end
    endtask

    // Called at a falling edge; returns 2 time units later after checking.
    task automatic set_in(input bit v, input logic [31:0] pc, input bit uv, input int ui,
                          input bit up, input bit ut, input bit st, input bit r);
        if_valid  = v;
        if_pc     = pc;
        upd_valid = uv;
        upd_idx   = 4'(ui);
        upd_pred  = up;
        upd_taken = ut;
        stall     = st;
        rst       = r;
        if (r) model_reset();
        #2;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; if_valid = 1'b0; if_pc = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_pred = 1'b0; upd_taken = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state and bimodal indexing
        set_in(1, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("t1_idx_40", bi_pred_idx, 0);
        chk("t1_pred_40", bi_pred_taken, 0);
        chk("t1_perf_br", bi_pb, 0);
        chk("t1_perf_mis", bi_pm, 0);
        tick();
        set_in(1, 32'h44, 0, 0, 0, 0, 0, 0);
        chk("t1_idx_44", bi_pred_idx, 1);
        tick();
        set_in(1, 32'h7C, 0, 0, 0, 0, 0, 0);
        chk("t1_idx_7c", bi_pred_idx, 15);
        chk("t1_pred_7c", bi_pred_taken, 0);
        tick();

        // Three taken commits to entry 3, saturating at 3
        for (int j = 0; j < 3; j++) begin
            set_in(1, 32'h0C, 1, 3, 0, 1, 0, 0);
            chk("t2_mispredict", bi_mis, 1);
            chk("t2_pred", bi_pred_taken, (j > 0) ? 1 : 0);
            tick();
        end
        set_in(1, 32'h0C, 0, 0, 0, 0, 0, 0);
        chk("t2_pred_after", bi_pred_taken, 1);
        chk("t2_ctr3_sat", u_bi.r_ctr_q[3], 3);
        chk("t2_perf_br", bi_pb, 3);
        chk("t2_perf_mis", bi_pm, 3);
        tick();

        // Two not-taken commits: 11 -> 10 -> 01
        set_in(1, 32'h0C, 1, 3, 1, 0, 0, 0);
        tick();
        set_in(1, 32'h0C, 1, 3, 1, 0, 0, 0);
        chk("t3_pred_ctr10", bi_pred_taken, 1);
        chk("t3_ctr3_10", u_bi.r_ctr_q[3], 2);
        tick();
        set_in(1, 32'h0C, 0, 0, 0, 0, 0, 0);
        chk("t3_pred_ctr01", bi_pred_taken, 0);
        chk("t3_ctr2", u_bi.r_ctr_q[2], 1);
        chk("t3_ctr4", u_bi.r_ctr_q[4], 1);
        chk("t3_perf_br", bi_pb, 5);
        tick();

        // Stalled update commits exactly once
        for (int j = 0; j < 5; j++) begin
            set_in(0, 32'h0, 1, 5, 0, 1, (j < 4), 0);
            chk("t4_mispredict", bi_mis, 1);
            chk("t4_ctr5_hold", u_bi.r_ctr_q[5], 1);
            tick();
        end
        set_in(0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("t4_ctr5_once", u_bi.r_ctr_q[5], 2);
        chk("t4_perf_br", bi_pb, 6);
        tick();

        // Same-cycle lookup/update: no bypass
        set_in(1, 32'h1C, 1, 7, 0, 1, 0, 0);
        chk("t5_pred_same", bi_pred_taken, 0);
        tick();
        set_in(1, 32'h1C, 0, 0, 0, 0, 0, 0);
        chk("t5_pred_next", bi_pred_taken, 1);

        // Asynchronous reset, then gshare history
        #1 rst = 1'b1;
        #1 model_reset();
        compare_all();
        chk("t6_rst0_perf", gs_pb, 0);
        tick();
        set_in(1, 32'h04, 1, 9, 0, 1, 0, 0);
        chk("t6_idx_ghr00", gs_pred_idx, 1);
        tick();
        set_in(1, 32'h04, 1, 9, 0, 0, 0, 0);
        chk("t6_idx_ghr01", gs_pred_idx, 0);
        tick();
        set_in(1, 32'h04, 0, 0, 0, 0, 0, 0);
        chk("t6_idx_ghr10", gs_pred_idx, 3);
        chk("t6_perf_br", gs_pb, 2);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_idx", gs_pred_idx, 1);
        chk("t6_rst_perf_br", gs_pb, 0);
        chk("t6_rst_perf_mis", gs_pm, 0);
        chk("t6_rst_ctr9", u_gs.r_ctr_q[9], 1);
        model_reset();
        compare_all();
        tick();

        // Randomized traffic with stalls and occasional resets
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15),
                   $urandom_range(0, 1),
                   (((i / 50) % 2) != 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
            tick();
        end
        set_in(1, 32'h0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
